// File: rtl/funcq_rx_buffer_if.sv
// Result/handshake bundle between funcQ, the receive buffer and its downstream consumer.
// master: funcQ plus consumer side; slave: the receive buffer.
interface funcq_rx_buffer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         Q_vld;
  logic signed [DATA_WIDTH-1:0] Q;
  logic                         out_vld;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_rdy;

  modport master (output Q_vld, Q, out_rdy, input out_vld, out_data);
  modport slave  (input Q_vld, Q, out_rdy, output out_vld, out_data);
endinterface

// File: rtl/funcq_rx_buffer.sv
// Receive FIFO for funcQ results with overflow tracking and saturating counters.
// Optional running min/max/sum statistics are enabled by defining FUNCQ_RX_STATS_EN.
module funcq_rx_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  funcq_rx_buffer_if.slave                      bus,
  output logic [LW-1:0]                         level,
  output logic                                  ovf,
  input  logic                                  ovf_clr,
  output logic [CNT_WIDTH-1:0]                  rx_cnt,
  output logic [CNT_WIDTH-1:0]                  drop_cnt,
  output logic signed [DATA_WIDTH-1:0]          stat_min,
  output logic signed [DATA_WIDTH-1:0]          stat_max,
  output logic signed [DATA_WIDTH+CNT_WIDTH-1:0] stat_sum,
  input  logic                                  stats_clr
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]   rx_cnt_q, rx_cnt_d;
  logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
  logic                   push, pop, drop, full, empty;

  // Full/empty come from the occupancy count so pointer equality never has to be disambiguated.
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign pop   = !empty && bus.out_rdy;
  assign push  = bus.Q_vld && (!full || pop);
  assign drop  = bus.Q_vld && !push;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d    = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
    rx_cnt_d   = push ? sat_inc(rx_cnt_q) : rx_cnt_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovf_d      = 1'b1;
      drop_cnt_d = ovf_clr ? CNT_WIDTH'(1) : sat_inc(drop_cnt_q);
    end else if (ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= bus.Q;
  end

  // Show-ahead read; forced to zero while empty so reset leaves out_data at 0.
  assign bus.out_vld  = !empty;
  assign bus.out_data = empty ? '0 : mem_q[rd_ptr_q];
  assign level        = level_q;
  assign ovf          = ovf_q;
  assign rx_cnt       = rx_cnt_q;
  assign drop_cnt     = drop_cnt_q;

`ifdef FUNCQ_RX_STATS_EN
  localparam logic signed [DATA_WIDTH-1:0] MIN_INIT = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] MAX_INIT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0]           stat_min_q, stat_min_d;
  logic signed [DATA_WIDTH-1:0]           stat_max_q, stat_max_d;
  logic signed [DATA_WIDTH+CNT_WIDTH-1:0] stat_sum_q, stat_sum_d;
  logic signed [DATA_WIDTH+CNT_WIDTH-1:0] q_ext;

  assign q_ext = {{CNT_WIDTH{bus.Q[DATA_WIDTH-1]}}, bus.Q};

  always_comb begin
    stat_min_d = stat_min_q;
    stat_max_d = stat_max_q;
    stat_sum_d = stat_sum_q;
    if (stats_clr) begin
      // A clear coinciding with a push restarts the statistics from that sample.
      stat_min_d = push ? bus.Q : MIN_INIT;
      stat_max_d = push ? bus.Q : MAX_INIT;
      stat_sum_d = push ? q_ext : '0;
    end else if (push) begin
      if (bus.Q < stat_min_q) stat_min_d = bus.Q;
      if (bus.Q > stat_max_q) stat_max_d = bus.Q;
      stat_sum_d = stat_sum_q + q_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_min_q <= MIN_INIT;
      stat_max_q <= MAX_INIT;
      stat_sum_q <= '0;
    end else begin
      stat_min_q <= stat_min_d;
      stat_max_q <= stat_max_d;
      stat_sum_q <= stat_sum_d;
    end
  end

  assign stat_min = stat_min_q;
  assign stat_max = stat_max_q;
  assign stat_sum = stat_sum_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign stat_min = '0;
  assign stat_max = '0;
  assign stat_sum = '0;
`endif

endmodule

// File: tb/tb_funcq_rx_buffer.sv
// Randomized and directed bench for funcq_rx_buffer against a queue-based reference model.
module tb_funcq_rx_buffer;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int CW = 16;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic ovf_clr, stats_clr, ovf;
  logic [LW-1:0] level;
  logic [CW-1:0] rx_cnt, drop_cnt;
  logic signed [DW-1:0] stat_min, stat_max;
  logic signed [DW+CW-1:0] stat_sum;

  always #5 clk = ~clk;

  funcq_rx_buffer_if #(.DATA_WIDTH(DW)) bus ();

  funcq_rx_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .level(level), .ovf(ovf), .ovf_clr(ovf_clr),
    .rx_cnt(rx_cnt), .drop_cnt(drop_cnt), .stat_min(stat_min), .stat_max(stat_max),
    .stat_sum(stat_sum), .stats_clr(stats_clr)
  );

  int n_chk = 0;
  int n_fail = 0;

  int q[$];
  int m_rx, m_drop;
  bit m_ovf;
  logic signed [DW-1:0] m_min, m_max;
  logic signed [DW+CW-1:0] m_sum;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rx = 0; m_drop = 0; m_ovf = 0;
    m_min = 16'sh7FFF; m_max = -16'sh8000; m_sum = '0;
  endtask

  task automatic model_step();
    bit pop, push, drop;
    int v;
    if (rst) begin
      model_reset();
      return;
    end
    v    = bus.Q;
    pop  = (q.size() != 0) && bus.out_rdy;
    push = bus.Q_vld && (q.size() < DEPTH || pop);
    drop = bus.Q_vld && !push;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(v);
    if (push && m_rx < MAXC) m_rx++;
    if (drop) begin
      m_ovf = 1;
      m_drop = ovf_clr ? 1 : ((m_drop < MAXC) ? m_drop + 1 : m_drop);
    end else if (ovf_clr) begin
      m_ovf = 0; m_drop = 0;
    end
    if (stats_clr) begin
      if (push) begin m_min = bus.Q; m_max = bus.Q; m_sum = v; end
      else begin m_min = 16'sh7FFF; m_max = -16'sh8000; m_sum = '0; end
    end else if (push) begin
      if (v < m_min) m_min = bus.Q;
      if (v > m_max) m_max = bus.Q;
      m_sum = m_sum + v;
    end
  endtask

  task automatic compare_all();
    check("out_vld", bus.out_vld, q.size() != 0);
    if (q.size() != 0) check("out_data", bus.out_data, q[0]);
    else check("out_data_idle", bus.out_data, 0);
    check("level", level, q.size());
    check("ovf", ovf, m_ovf);
    check("rx_cnt", rx_cnt, m_rx);
    check("drop_cnt", drop_cnt, m_drop);
`ifdef FUNCQ_RX_STATS_EN
    check("stat_min", stat_min, m_min);
    check("stat_max", stat_max, m_max);
    check("stat_sum", stat_sum, m_sum);
`else
    check("stat_min_off", stat_min, 0);
    check("stat_max_off", stat_max, 0);
    check("stat_sum_off", stat_sum, 0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    rst = 0; bus.Q_vld = 0; bus.Q = '0; bus.out_rdy = 0; ovf_clr = 0; stats_clr = 0;
  endtask

  task automatic push_one(input int v);
    bus.Q_vld = 1; bus.Q = DW'(v);
    tick();
    bus.Q_vld = 0;
  endtask

  int pct_vld, pct_rdy;

  initial begin
    idle();
    model_reset();
    rst = 1;
    repeat (10) tick();
    rst = 0;
    check("rst_out_vld", bus.out_vld, 0);
    check("rst_level", level, 0);
    check("rst_rx_cnt", rx_cnt, 0);

    // Single results with a ready consumer
    bus.out_rdy = 1;
    push_one(5);
    check("single_vld", bus.out_vld, 1);
    check("single_data", bus.out_data, 5);
    tick();
    check("single_drained", level, 0);
    push_one(-3);
    check("neg_data", bus.out_data, -3);
    check("neg_rx_cnt", rx_cnt, 2);
    tick();

    // Backpressured burst fills the FIFO exactly
    bus.out_rdy = 0;
    for (int i = 1; i <= 8; i++) push_one(i);
    check("burst_level", level, 8);
    check("burst_ovf", ovf, 0);
    bus.out_rdy = 1;
    for (int i = 1; i <= 8; i++) begin
      check("burst_order", bus.out_data, i);
      tick();
    end
    check("burst_empty", bus.out_vld, 0);

    // Overflow, clear, and push-while-full-with-pop
    bus.out_rdy = 0;
    for (int i = 1; i <= 8; i++) push_one(20 + i);
    push_one(9);
    push_one(10);
    check("ovf_drop_cnt", drop_cnt, 2);
    check("ovf_flag", ovf, 1);
    ovf_clr = 1; tick(); ovf_clr = 0;
    check("ovf_clr_flag", ovf, 0);
    check("ovf_clr_cnt", drop_cnt, 0);
    bus.out_rdy = 1;
    push_one(11);
    check("full_pushpop_level", level, 8);
    bus.out_rdy = 0;
    bus.Q_vld = 1; bus.Q = DW'(12); ovf_clr = 1;
    tick();
    idle();
    check("clr_drop_same_cnt", drop_cnt, 1);
    check("clr_drop_same_ovf", ovf, 1);
    bus.out_rdy = 1;
    repeat (8) tick();
    check("drain_empty", level, 0);

    // Reset in mid-operation discards contents and ignores Q_vld
    bus.out_rdy = 0;
    for (int i = 0; i < 4; i++) push_one(40 + i);
    check("mid_level", level, 4);
    rst = 1; bus.Q_vld = 1; bus.Q = DW'(99);
    tick();
    idle();
    check("mid_rst_level", level, 0);
    check("mid_rst_vld", bus.out_vld, 0);
    push_one(7);
    check("post_rst_first", bus.out_data, 7);
    bus.out_rdy = 1;
    tick();

    // Statistics
    stats_clr = 1; tick(); stats_clr = 0;
    push_one(5); push_one(-2); push_one(3);
`ifdef FUNCQ_RX_STATS_EN
    check("stats_min", stat_min, -2);
    check("stats_max", stat_max, 5);
    check("stats_sum", stat_sum, 6);
`else
    check("stats_off_min", stat_min, 0);
`endif
    stats_clr = 1; push_one(4); stats_clr = 0;
`ifdef FUNCQ_RX_STATS_EN
    check("stats_reload_min", stat_min, 4);
    check("stats_reload_max", stat_max, 4);
    check("stats_reload_sum", stat_sum, 4);
`else
    check("stats_off_sum", stat_sum, 0);
`endif
    repeat (4) tick();

    // Random traffic with varying load and backpressure
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        pct_vld = $urandom_range(10, 100);
        pct_rdy = $urandom_range(0, 100);
      end
      bus.Q_vld   = ($urandom_range(0, 99) < pct_vld);
      bus.Q       = DW'($urandom);
      bus.out_rdy = ($urandom_range(0, 99) < pct_rdy);
      ovf_clr     = ($urandom_range(0, 49) == 0);
      stats_clr   = ($urandom_range(0, 99) == 0);
      rst         = ($urandom_range(0, 999) == 0);
      tick();
    end
    idle();
    bus.out_rdy = 1;
    repeat (DEPTH + 2) tick();
    check("final_empty", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
